siso_frame_rx: RTL and testbench

- Downstream consumer of the 4-bit SISO shift register; its `sin` input is fed directly from the shift register's `sout`.
- Finds framed serial words on that line, shifts them into a parallel register and presents each word through a one-entry valid/ready output buffer.
- Flags bad stop bits and words lost to back-pressure.
- One bit is sampled on every rising clock edge, matching the shift register's one-bit-per-clock rate.

---
 rtl/siso_frame_rx.sv | 149 ++++++++++++++
 tb/tb_siso_frame_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_frame_rx.sv
// -----------------------------------------------------------------------------
// siso_frame_rx
//
// Receives framed serial words from an upstream SISO shift register, one bit
// per rising clock edge.  Frame on sin: start bit (1), DATA_W payload bits LSB
// first, optional even-parity bit, stop bit (0).  The line idles at 0.  Each
// good word goes into a one-entry valid/ready output buffer.
//
// Configuration macro:
//   PARITY_EN  - when defined, a parity bit sits between payload and stop bit
//                and the parity_err port exists.  Undefined by default.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   sin         in   serial line (upstream SISO sout)
//   data_ready  in   consumer accepts data_out when data_valid=1
//   data_out    out  [DATA_W] received word, bit 0 = first payload bit
//   data_valid  out  data_out holds an unconsumed word
//   busy        out  receiver is inside a frame
//   frame_err   out  one-cycle pulse: stop bit was 1
//   overflow    out  sticky: good word dropped because the buffer was full
//   parity_err  out  one-cycle pulse: parity mismatch (PARITY_EN only)
// -----------------------------------------------------------------------------
module siso_frame_rx #(
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sin,
   input  logic              data_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              busy,
   output logic              frame_err,
   output logic              overflow
`ifdef PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      STOP = 2'd3
   } state_t;

`ifdef PARITY_EN
   localparam state_t AFTER_DATA = PAR;
`else
   localparam state_t AFTER_DATA = STOP;
`endif

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;

   logic last_bit;
   logic stop_edge;
   logic par_bad;
   logic good_frame;
   logic consume;
   logic load;

`ifdef PARITY_EN
   logic par_bit;
   // Even parity: payload plus parity bit must XOR to zero.
   assign par_bad = ^{shreg, par_bit};
`else
   assign par_bad = 1'b0;
`endif

   assign last_bit   = (bit_cnt == CNT_W'(DATA_W - 1));
   assign stop_edge  = (state == STOP);
   assign good_frame = stop_edge && !sin && !par_bad;
   assign consume    = data_valid && data_ready;
   // A word already in the buffer leaves on this same edge when data_ready is
   // high, so the new word may take its place without a bubble.
   assign load       = good_frame && (!data_valid || data_ready);

   // NOTE: every variable assigned in always_comb gets a default first, so
   // no path through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (sin) state_next = DATA;
         DATA:    if (last_bit) state_next = AFTER_DATA;
         PAR:     state_next = STOP;
         STOP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
      end
   end

   // NOTE: the datapath is reset along with the control, because data_out is
   // observable and must read zero after reset rather than stale bits.
   always_ff @(posedge clock) begin
      if (reset) begin
         bit_cnt    <= '0;
         shreg      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
`ifdef PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err <= stop_edge && sin;
`ifdef PARITY_EN
         parity_err <= stop_edge && par_bad;
         if (state == PAR) par_bit <= sin;
`endif
         // Shift in at the MSB: after DATA_W shifts the first bit sits at bit 0.
         // The counter returns to 0 on the last bit, ready for the next frame.
         if (state == DATA) begin
            shreg   <= {sin, shreg[DATA_W-1:1]};
            bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
         end

         if (load) begin
            data_out   <= shreg;
            data_valid <= 1'b1;
         end else if (consume) begin
            data_valid <= 1'b0;
         end

         if (good_frame && data_valid && !data_ready) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_siso_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_siso_frame_rx
//
// Directed bench for siso_frame_rx (DATA_W = 8).  A frame-level reference
// model collects line bits into a queue and decides the outcome of each frame
// once its stop bit arrives; a compare process checks every DUT output against
// it one time unit after each rising edge.  Literal checks at key points pin
// both the DUT and the model.  Inputs change on the falling edge.
// Build with +define+PARITY_EN to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_siso_frame_rx;

   localparam int DATA_W = 8;
`ifdef PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic              clock;
   logic              reset;
   logic              sin;
   logic              data_ready;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              busy;
   logic              frame_err;
   logic              overflow;
`ifdef PARITY_EN
   logic              parity_err;
`endif

   int n_checks = 0;
   int n_errors = 0;

   siso_frame_rx #(.DATA_W(DATA_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .sin        (sin),
      .data_ready (data_ready),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .overflow   (overflow)
`ifdef PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   logic              m_in_frame;
   logic              m_bits[$];
   logic [DATA_W-1:0] m_word;
   logic [DATA_W-1:0] m_data;
   logic              m_valid, m_ovf, m_ferr, m_perr, m_busy, m_take;
   int                m_ones;

   always @(posedge clock) begin
      if (reset) begin
         m_in_frame = 1'b0;
         m_bits.delete();
         m_data  = '0;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         m_ferr  = 1'b0;
         m_perr  = 1'b0;
         m_busy  = 1'b0;
      end else begin
         m_ferr = 1'b0;
         m_perr = 1'b0;
         m_take = m_valid && data_ready;
         if (!m_in_frame) begin
            if (sin === 1'b1) begin
               m_in_frame = 1'b1;
               m_bits.delete();
            end
         end else begin
            m_bits.push_back(sin);
            if (m_bits.size() == DATA_W + PAR_BITS + 1) begin
               m_in_frame = 1'b0;
               m_ones = 0;
               for (int i = 0; i < DATA_W + PAR_BITS; i++) m_ones += int'(m_bits[i]);
               for (int i = 0; i < DATA_W; i++) m_word[i] = m_bits[i];
               m_ferr = m_bits[DATA_W + PAR_BITS];
               m_perr = (PAR_BITS == 1) && (m_ones % 2 == 1);
               if (!m_ferr && !m_perr) begin
                  if (!m_valid || data_ready) begin
                     m_data  = m_word;
                     m_valid = 1'b1;
                     m_take  = 1'b0;
                  end else begin
                     m_ovf = 1'b1;
                  end
               end
            end
         end
         if (m_take) m_valid = 1'b0;
         m_busy = m_in_frame;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clock) begin
      #1;
      check("cyc data_out",   32'(data_out),   32'(m_data));
      check("cyc data_valid", 32'(data_valid), 32'(m_valid));
      check("cyc busy",       32'(busy),       32'(m_busy));
      check("cyc frame_err",  32'(frame_err),  32'(m_ferr));
      check("cyc overflow",   32'(overflow),   32'(m_ovf));
`ifdef PARITY_EN
      check("cyc parity_err", 32'(parity_err), 32'(m_perr));
`endif
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_bit(input logic b);
      @(negedge clock);
      sin = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0);
   endtask

   // Drives a whole frame; the stop bit is on the line when this returns, so
   // the next falling edge lies just after the stop edge.
   task automatic send_frame(input logic [DATA_W-1:0] w, input logic stop_bit,
                             input logic par_bit, input logic ready_on_stop);
      send_bit(1'b1);
      for (int i = 0; i < DATA_W; i++) send_bit(w[i]);
      if (PAR_BITS == 1) send_bit(par_bit);
      @(negedge clock);
      sin = stop_bit;
      if (ready_on_stop) data_ready = 1'b1;
   endtask

   task automatic send_good(input logic [DATA_W-1:0] w);
      send_frame(w, 1'b0, ^w, 1'b0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clock);
      reset = 1'b1;
      sin   = 1'b0;
      repeat (n) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      sin        = 1'b0;
      data_ready = 1'b0;
      repeat (3) @(negedge clock);
      check("reset busy",       32'(busy),       32'd0);
      check("reset data_valid", 32'(data_valid), 32'd0);
      check("reset data_out",   32'(data_out),   32'h00);
      reset = 1'b0;

      // Idle line for 20 cycles
      idle(20);
      check("idle busy",       32'(busy),       32'd0);
      check("idle data_valid", 32'(data_valid), 32'd0);
      check("idle data_out",   32'(data_out),   32'h00);

      // Good frame A5 with latency check
      data_ready = 1'b1;
      send_good(8'hA5);
      check("A5 busy before stop", 32'(busy),       32'd1);
      check("A5 valid before stop", 32'(data_valid), 32'd0);
      idle(1);
      check("A5 data_valid", 32'(data_valid), 32'd1);
      check("A5 data_out",   32'(data_out),   32'hA5);
      check("A5 model",      32'(m_data),     32'hA5);
      check("A5 busy after", 32'(busy),       32'd0);
      idle(1);
      check("A5 consumed", 32'(data_valid), 32'd0);
      check("A5 held",     32'(data_out),   32'hA5);

      // Back-pressure: 3C buffered, C3 back-to-back is dropped
      data_ready = 1'b0;
      send_good(8'h3C);
      send_good(8'hC3);
      idle(2);
      check("bp data_out",  32'(data_out),   32'h3C);
      check("bp valid",     32'(data_valid), 32'd1);
      check("bp overflow",  32'(overflow),   32'd1);
      check("bp model ovf", 32'(m_ovf),      32'd1);
      @(negedge clock);
      data_ready = 1'b1;
      idle(1);
      check("bp drained valid", 32'(data_valid), 32'd0);
      check("bp sticky ovf",    32'(overflow),   32'd1);
      idle(3);
      check("bp sticky ovf 2",  32'(overflow),   32'd1);
      do_reset(2);
      check("reset clears ovf", 32'(overflow), 32'd0);

      // Bad stop bit, then a good frame
      data_ready = 1'b1;
      send_frame(8'h0F, 1'b1, ^(8'h0F), 1'b0);
      idle(1);
      check("bad stop frame_err", 32'(frame_err),  32'd1);
      check("bad stop valid",     32'(data_valid), 32'd0);
      idle(1);
      check("frame_err one cycle", 32'(frame_err), 32'd0);
      send_good(8'h01);
      idle(1);
      check("after bad valid", 32'(data_valid), 32'd1);
      check("after bad data",  32'(data_out),   32'h01);
      idle(2);

      // Consume and load on the same edge
      data_ready = 1'b0;
      send_good(8'h11);
      idle(2);
      check("sim 11 buffered", 32'(data_out), 32'h11);
      send_frame(8'h22, 1'b0, ^(8'h22), 1'b1);
      @(negedge clock);
      sin        = 1'b0;
      data_ready = 1'b0;
      check("sim data_out", 32'(data_out),   32'h22);
      check("sim valid",    32'(data_valid), 32'd1);
      check("sim overflow", 32'(overflow),   32'd0);
      data_ready = 1'b1;
      idle(2);

      // Reset after 4 payload bits
      send_bit(1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      do_reset(2);
      check("mid reset busy",  32'(busy),      32'd0);
      check("mid reset ferr",  32'(frame_err), 32'd0);
      check("mid reset valid", 32'(data_valid), 32'd0);
      idle(2);
      send_good(8'h5A);
      idle(1);
      check("post reset data",  32'(data_out),   32'h5A);
      check("post reset valid", 32'(data_valid), 32'd1);
      idle(2);

`ifdef PARITY_EN
      // Parity: bad parity dropped, good parity accepted, both errors together
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      idle(1);
      check("par bad pulse", 32'(parity_err), 32'd1);
      check("par bad valid", 32'(data_valid), 32'd0);
      idle(1);
      check("par pulse one cycle", 32'(parity_err), 32'd0);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      idle(1);
      check("par good data", 32'(data_out),   32'hA5);
      check("par good perr", 32'(parity_err), 32'd0);
      idle(2);
      send_frame(8'h01, 1'b1, 1'b0, 1'b0);
      idle(1);
      check("both perr", 32'(parity_err), 32'd1);
      check("both ferr", 32'(frame_err),  32'd1);
      idle(2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
